// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the fetch/data memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    i_req_valid;
  logic                    i_req_ready;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic                    i_rsp_valid;
  logic [DATA_WIDTH-1:0]   i_rsp_data;
  logic                    d_req_valid;
  logic                    d_req_ready;
  logic [ADDR_WIDTH-1:0]   d_req_addr;
  logic                    d_req_we;
  logic [DATA_WIDTH-1:0]   d_req_wdata;
  logic [DATA_WIDTH/8-1:0] d_req_wstrb;
  logic                    d_rsp_valid;
  logic [DATA_WIDTH-1:0]   d_rsp_data;
  logic                    m_req_valid;
  logic                    m_req_ready;
  logic [ADDR_WIDTH-1:0]   m_req_addr;
  logic                    m_req_we;
  logic [DATA_WIDTH-1:0]   m_req_wdata;
  logic [DATA_WIDTH/8-1:0] m_req_wstrb;
  logic                    m_rsp_valid;
  logic [DATA_WIDTH-1:0]   m_rsp_data;
  logic                    err_unexp_rsp;
  modport slave (
    input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
           m_req_ready, m_rsp_valid, m_rsp_data,
    output i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
           m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wstrb, err_unexp_rsp
  );
  modport master (
    output i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
           m_req_ready, m_rsp_valid, m_rsp_data,
    input  i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
           m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wstrb, err_unexp_rsp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters, one transaction in flight
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              areset_n,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [1:0]              r_state;
  logic [3:0]              r_starve;
  logic                    r_owner;
  logic                    r_err;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    w_idle;
  logic                    w_gnt_i;
  logic                    w_gnt_d;
  logic                    w_rsp;
  // reset gating keeps the grant readies low while reset is held
  assign w_idle  = areset_n && r_state == IDLE;
  assign w_gnt_i = w_idle && bus.i_req_valid && (!bus.d_req_valid || r_starve == LIM);
  assign w_gnt_d = w_idle && bus.d_req_valid && !w_gnt_i;
  assign w_rsp   = r_state == RSP && bus.m_rsp_valid;
  assign bus.i_req_ready   = w_gnt_i;
  assign bus.d_req_ready   = w_gnt_d;
  assign bus.i_rsp_valid   = w_rsp && !r_owner;
  assign bus.d_rsp_valid   = w_rsp && r_owner;
  assign bus.i_rsp_data    = bus.m_rsp_data;
  assign bus.d_rsp_data    = bus.m_rsp_data;
  assign bus.m_req_valid   = r_state == REQ;
  assign bus.m_req_addr    = r_addr;
  assign bus.m_req_we      = r_we;
  assign bus.m_req_wdata   = r_wdata;
  assign bus.m_req_wstrb   = r_wstrb;
  assign bus.err_unexp_rsp = r_err;
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_owner  <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (bus.m_rsp_valid && r_state != RSP) r_err <= 1'b1;
      if (w_gnt_i || w_gnt_d) begin
        r_state  <= REQ;
        r_owner  <= w_gnt_d;
        r_addr   <= w_gnt_d ? bus.d_req_addr : bus.i_req_addr;
        r_we     <= w_gnt_d && bus.d_req_we;
        r_wdata  <= w_gnt_d ? bus.d_req_wdata : '0;
        r_wstrb  <= w_gnt_d ? bus.d_req_wstrb : '0;
        r_starve <= (w_gnt_d && bus.i_req_valid) ? ((r_starve == LIM) ? LIM : r_starve + 4'd1) : 4'd0;
      end else if (r_state == REQ && bus.m_req_ready) begin
        r_state <= RSP;
      end else if (w_rsp) begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic areset_n = 1'b0;
  int total = 0;
  int bad = 0;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .areset_n(areset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.i_req_valid = 0; bus.i_req_addr = '0;
    bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_we = 0;
    bus.d_req_wdata = '0; bus.d_req_wstrb = '0;
    bus.m_req_ready = 0; bus.m_rsp_valid = 0; bus.m_rsp_data = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.i_req_valid = 1; bus.d_req_valid = 1; bus.m_rsp_valid = 1;
    #2;
    total++; if ({bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid} !== 4'b0) begin bad++; $display("FAIL reset_outs got=%b exp=0000", {bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid}); end
    total++; if ({bus.m_req_valid, bus.m_req_we, bus.err_unexp_rsp} !== 3'b0) begin bad++; $display("FAIL reset_mreq got=%b exp=000", {bus.m_req_valid, bus.m_req_we, bus.err_unexp_rsp}); end
    total++; if (bus.m_req_addr !== 32'h0 || bus.m_req_wdata !== 32'h0 || bus.m_req_wstrb !== 4'h0) begin bad++; $display("FAIL reset_mregs got=%h/%h/%h exp=0", bus.m_req_addr, bus.m_req_wdata, bus.m_req_wstrb); end
    tick(); tick();
    idle_inputs();
    areset_n = 1;
  endtask

  task automatic test_lone_fetch;
    tick();
    bus.i_req_valid = 1; bus.i_req_addr = 32'h100; bus.m_req_ready = 1;
    #1;
    total++; if (bus.i_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin bad++; $display("FAIL fetch_grant got=%b%b exp=10", bus.i_req_ready, bus.d_req_ready); end
    tick();
    bus.i_req_valid = 0; bus.i_req_addr = 32'hFFFF_FFFF;
    #1;
    total++; if (bus.m_req_valid !== 1'b1 || bus.m_req_addr !== 32'h100 || bus.m_req_we !== 1'b0 || bus.m_req_wstrb !== 4'h0) begin bad++; $display("FAIL fetch_mreq got=%b %h %b %h exp=1 100 0 0", bus.m_req_valid, bus.m_req_addr, bus.m_req_we, bus.m_req_wstrb); end
    tick();
    bus.m_req_ready = 0; bus.m_rsp_valid = 1; bus.m_rsp_data = 32'hDEADBEEF;
    #1;
    total++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_data !== 32'hDEADBEEF || bus.d_rsp_valid !== 1'b0) begin bad++; $display("FAIL fetch_rsp got=%b %h %b exp=1 deadbeef 0", bus.i_rsp_valid, bus.i_rsp_data, bus.d_rsp_valid); end
    tick();
    bus.m_rsp_valid = 0;
    #1;
    total++; if (bus.m_req_valid !== 1'b0 || bus.i_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin bad++; $display("FAIL fetch_done got=%b%b%b exp=000", bus.m_req_valid, bus.i_rsp_valid, bus.d_rsp_valid); end
  endtask

  task automatic test_starvation;
    int cnt = 0;
    bit exp_i;
    string seq = "";
    tick();
    bus.i_req_valid = 1; bus.d_req_valid = 1; bus.m_req_ready = 1;
    for (int g = 0; g < 10; g++) begin
      exp_i = (cnt == LIMIT);
      cnt = exp_i ? 0 : cnt + 1;
      #1;
      seq = {seq, bus.i_req_ready ? "I" : bus.d_req_ready ? "D" : "-"};
      total++; if (bus.i_req_ready !== exp_i || bus.d_req_ready !== !exp_i) begin bad++; $display("FAIL starve_grant%0d got=%b%b exp=%b%b", g, bus.i_req_ready, bus.d_req_ready, exp_i, !exp_i); end
      tick();
      tick();
      bus.m_rsp_valid = 1; bus.m_rsp_data = $urandom;
      #1;
      total++; if (bus.i_rsp_valid !== exp_i || bus.d_rsp_valid !== !exp_i) begin bad++; $display("FAIL starve_rsp%0d got=%b%b exp=%b%b", g, bus.i_rsp_valid, bus.d_rsp_valid, exp_i, !exp_i); end
      tick();
      bus.m_rsp_valid = 0;
    end
    total++; if (seq != "DDDDIDDDDI") begin bad++; $display("FAIL starve_order got=%s exp=DDDDIDDDDI", seq); end
    idle_inputs();
  endtask

  task automatic test_write_stall;
    tick();
    bus.d_req_valid = 1; bus.d_req_we = 1; bus.d_req_addr = 32'h40;
    bus.d_req_wdata = 32'h12345678; bus.d_req_wstrb = 4'b0011;
    #1;
    total++; if (bus.d_req_ready !== 1'b1) begin bad++; $display("FAIL wr_grant got=%b exp=1", bus.d_req_ready); end
    tick();
    bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_addr = 32'hBAD0;
    bus.d_req_wdata = 32'h0; bus.d_req_wstrb = 4'hF;
    for (int k = 0; k < 6; k++) begin
      bus.m_req_ready = (k == 5);
      #1;
      total++; if (bus.m_req_valid !== 1'b1 || bus.m_req_addr !== 32'h40 || bus.m_req_we !== 1'b1 || bus.m_req_wdata !== 32'h12345678 || bus.m_req_wstrb !== 4'b0011) begin bad++; $display("FAIL wr_stable%0d got=%b %h %b %h %h exp=1 40 1 12345678 3", k, bus.m_req_valid, bus.m_req_addr, bus.m_req_we, bus.m_req_wdata, bus.m_req_wstrb); end
      tick();
    end
    bus.m_req_ready = 0; bus.m_rsp_valid = 1;
    #1;
    total++; if (bus.d_rsp_valid !== 1'b1 || bus.i_rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b%b exp=10", bus.d_rsp_valid, bus.i_rsp_valid); end
    tick();
    bus.m_rsp_valid = 0;
    #1;
    total++; if (bus.d_rsp_valid !== 1'b0 || bus.m_req_valid !== 1'b0) begin bad++; $display("FAIL wr_ack_once got=%b%b exp=00", bus.d_rsp_valid, bus.m_req_valid); end
  endtask

  task automatic test_fetch_delay;
    tick();
    bus.i_req_valid = 1; bus.i_req_addr = 32'h200;
    #1;
    total++; if (bus.i_req_ready !== 1'b1) begin bad++; $display("FAIL fd_grant got=%b exp=1", bus.i_req_ready); end
    tick();
    bus.i_req_valid = 0; bus.d_req_valid = 1; bus.d_req_addr = 32'h300; bus.m_req_ready = 1;
    #1;
    total++; if (bus.d_req_ready !== 1'b0) begin bad++; $display("FAIL fd_req_busy got=%b exp=0", bus.d_req_ready); end
    tick();
    bus.m_req_ready = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++; if (bus.d_req_ready !== 1'b0 || bus.i_rsp_valid !== 1'b0) begin bad++; $display("FAIL fd_wait%0d got=%b%b exp=00", k, bus.d_req_ready, bus.i_rsp_valid); end
      tick();
    end
    bus.m_rsp_valid = 1; bus.m_rsp_data = 32'hCAFE0001;
    #1;
    total++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_data !== 32'hCAFE0001 || bus.d_req_ready !== 1'b0) begin bad++; $display("FAIL fd_rsp got=%b %h %b exp=1 cafe0001 0", bus.i_rsp_valid, bus.i_rsp_data, bus.d_req_ready); end
    tick();
    bus.m_rsp_valid = 0;
    #1;
    total++; if (bus.d_req_ready !== 1'b1) begin bad++; $display("FAIL fd_dgrant got=%b exp=1", bus.d_req_ready); end
    tick();
    bus.d_req_valid = 0; bus.m_req_ready = 1;
    #1;
    total++; if (bus.m_req_addr !== 32'h300) begin bad++; $display("FAIL fd_daddr got=%h exp=300", bus.m_req_addr); end
    tick();
    bus.m_req_ready = 0; bus.m_rsp_valid = 1;
    tick();
    bus.m_rsp_valid = 0;
  endtask

  task automatic test_unexp_rsp;
    tick();
    bus.m_rsp_valid = 1; bus.m_rsp_data = 32'h5555AAAA;
    #1;
    total++; if (bus.i_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin bad++; $display("FAIL unexp_route got=%b%b exp=00", bus.i_rsp_valid, bus.d_rsp_valid); end
    tick();
    bus.m_rsp_valid = 0;
    #1;
    total++; if (bus.err_unexp_rsp !== 1'b1) begin bad++; $display("FAIL unexp_err got=%b exp=1", bus.err_unexp_rsp); end
    for (int k = 0; k < 5; k++) tick();
    total++; if (bus.err_unexp_rsp !== 1'b1) begin bad++; $display("FAIL unexp_sticky got=%b exp=1", bus.err_unexp_rsp); end
  endtask

  task automatic test_reset_mid;
    tick();
    bus.d_req_valid = 1; bus.d_req_we = 0; bus.d_req_addr = 32'h80;
    tick();
    bus.d_req_valid = 0; bus.m_req_ready = 1;
    tick();
    bus.m_req_ready = 0;
    #1;
    areset_n = 0;
    bus.i_req_valid = 1; bus.d_req_valid = 1;
    #1;
    total++; if (bus.err_unexp_rsp !== 1'b0 || bus.m_req_valid !== 1'b0 || bus.m_req_addr !== 32'h0) begin bad++; $display("FAIL rm_clear got=%b %b %h exp=0 0 0", bus.err_unexp_rsp, bus.m_req_valid, bus.m_req_addr); end
    tick();
    total++; if ({bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid} !== 4'b0) begin bad++; $display("FAIL rm_outs got=%b exp=0000", {bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid}); end
    idle_inputs();
    areset_n = 1;
    tick();
    bus.m_rsp_valid = 1;
    #1;
    total++; if (bus.i_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0 || bus.m_req_valid !== 1'b0) begin bad++; $display("FAIL rm_late got=%b%b%b exp=000", bus.i_rsp_valid, bus.d_rsp_valid, bus.m_req_valid); end
    tick();
    bus.m_rsp_valid = 0; bus.i_req_valid = 1;
    #1;
    total++; if (bus.err_unexp_rsp !== 1'b1 || bus.i_req_ready !== 1'b1) begin bad++; $display("FAIL rm_err_idle got=%b%b exp=11", bus.err_unexp_rsp, bus.i_req_ready); end
    bus.i_req_valid = 0;
    #1;
    areset_n = 0;
    tick();
    areset_n = 1;
  endtask

  task automatic test_random;
    int ph = 0;
    int cnt = 0;
    bit own_d = 0;
    bit egi, egd;
    logic [31:0] ea, ewd;
    logic ewe;
    logic [3:0] ews;
    for (int c = 0; c < 600; c++) begin
      tick();
      bus.i_req_valid = 1'($urandom_range(0, 1)); bus.i_req_addr = $urandom;
      bus.d_req_valid = 1'($urandom_range(0, 1)); bus.d_req_addr = $urandom;
      bus.d_req_we = 1'($urandom_range(0, 1)); bus.d_req_wdata = $urandom; bus.d_req_wstrb = 4'($urandom);
      bus.m_req_ready = 1'($urandom_range(0, 2) != 0);
      bus.m_rsp_valid = (ph == 2) && ($urandom_range(0, 2) == 0);
      bus.m_rsp_data = $urandom;
      #1;
      egi = ph == 0 && bus.i_req_valid && (!bus.d_req_valid || cnt == LIMIT);
      egd = ph == 0 && bus.d_req_valid && !egi;
      total++; if (bus.i_req_ready !== egi || bus.d_req_ready !== egd) begin bad++; $display("FAIL rnd_grant c=%0d got=%b%b exp=%b%b", c, bus.i_req_ready, bus.d_req_ready, egi, egd); end
      total++; if (bus.m_req_valid !== (ph == 1)) begin bad++; $display("FAIL rnd_mvalid c=%0d got=%b exp=%b", c, bus.m_req_valid, ph == 1); end
      if (ph == 1) begin
        total++; if (bus.m_req_addr !== ea || bus.m_req_we !== ewe || bus.m_req_wstrb !== ews || (own_d && bus.m_req_wdata !== ewd)) begin bad++; $display("FAIL rnd_mreq c=%0d got=%h %b %h %h exp=%h %b %h %h", c, bus.m_req_addr, bus.m_req_we, bus.m_req_wstrb, bus.m_req_wdata, ea, ewe, ews, ewd); end
      end
      total++; if (bus.i_rsp_valid !== (bus.m_rsp_valid && !own_d) || bus.d_rsp_valid !== (bus.m_rsp_valid && own_d) || bus.i_rsp_data !== bus.m_rsp_data || bus.d_rsp_data !== bus.m_rsp_data) begin bad++; $display("FAIL rnd_rsp c=%0d got=%b%b exp=%b%b", c, bus.i_rsp_valid, bus.d_rsp_valid, bus.m_rsp_valid && !own_d, bus.m_rsp_valid && own_d); end
      if (egi || egd) begin
        own_d = egd;
        ea = egd ? bus.d_req_addr : bus.i_req_addr;
        ewe = egd && bus.d_req_we;
        ews = egd ? bus.d_req_wstrb : 4'h0;
        ewd = bus.d_req_wdata;
        cnt = (egd && bus.i_req_valid) ? ((cnt < LIMIT) ? cnt + 1 : LIMIT) : 0;
        ph = 1;
      end else if (ph == 1 && bus.m_req_ready) ph = 2;
      else if (ph == 2 && bus.m_rsp_valid) ph = 0;
    end
    total++; if (bus.err_unexp_rsp !== 1'b0) begin bad++; $display("FAIL rnd_err got=%b exp=0", bus.err_unexp_rsp); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_starvation();
    test_write_stall();
    test_fetch_delay();
    test_unexp_rsp();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port memory between the instruction-fetch requester and the data-access requester, so the core can run from one unified memory instead of separate instruction and data memories. Each requester uses a valid/ready request handshake and receives a single-cycle response pulse. The block sits between the fetch/load-store logic and the memory. It holds exactly one outstanding transaction and latches it. Data accesses win by default; a starvation counter guarantees fetch progress.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits; legal range 1..15
- clk  in  1  clock, all state on rising edge
- areset_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  ADDR_WIDTH  fetch address
- i_rsp_valid  out  1  fetch response pulse
- i_rsp_data  out  DATA_WIDTH  fetch read data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_WIDTH  data address
- d_req_we  in  1  1 = write
- d_req_wdata  in  DATA_WIDTH  write data
- d_req_wstrb  in  DATA_WIDTH/8  byte enables
- d_rsp_valid  out  1  data response pulse (read data or write ack)
- d_rsp_data  out  DATA_WIDTH  data read data
- m_req_valid  out  1  memory request
- m_req_ready  in  1  memory accepts request
- m_req_addr, m_req_we, m_req_wdata, m_req_wstrb  out  as d_req_*  latched request
- m_rsp_valid  in  1  memory response, one per accepted request including writes
- m_rsp_data  in  DATA_WIDTH  memory read data
- err_unexp_rsp  out  1  sticky: m_rsp_valid seen outside RSP state

## Operation
- FSM states:
  - IDLE: no transaction held. Arbitrate.
  - REQ: m_req_valid=1, wait for m_req_ready.
  - RSP: wait for m_rsp_valid.
- IDLE arbitration happens only in IDLE; ready outputs are 0 in the other states.
  - Only one valid: grant that requester.
  - Both valid: grant data, unless starve_cnt == STARVE_LIMIT, then grant fetch.
  - On a grant, the winner's ready is 1 combinationally. The request is latched into m_req_* registers along with owner (I/D). The FSM goes to REQ.
  - Fetch grants drive m_req_we=0 and m_req_wstrb=0.
- Starvation counter (4 bit, saturating at STARVE_LIMIT):
  - On a data grant with i_req_valid=1: increment.
  - On a fetch grant, or a data grant with i_req_valid=0: clear.
- REQ: when m_req_ready=1, go to RSP. m_req_* are held stable while m_req_valid=1.
- RSP: when m_rsp_valid=1, the owner's rsp_valid is 1 in the same cycle (combinational).
  - The owner's rsp_data equals m_rsp_data; the other requester's rsp_valid stays 0.
  - The FSM returns to IDLE.
- i_rsp_data and d_rsp_data are driven from m_rsp_data at all times. They are valid only with the matching rsp_valid.
- m_rsp_valid in IDLE or REQ: ignored, no response routed, err_unexp_rsp set until reset.
- Requester inputs are not sampled outside a grant cycle; they may change freely once the request is accepted.

## Timing
- Reset values: state=IDLE, starve_cnt=0, owner=I, err_unexp_rsp=0.
  - All m_req_* registers are 0.
  - i_req_ready, d_req_ready, i_rsp_valid and d_rsp_valid are all 0 during reset, since the state is not IDLE-granting until reset is released. Ready may assert in the first cycle after deassertion.
- Reset mid-transaction: the transaction is discarded and no response is delivered. A late m_rsp_valid after reset sets err_unexp_rsp.
- Minimum latency, with memory always ready and a 1-cycle response:
  - cycle 0: grant (ready=1)
  - cycle 1: m_req_valid=1 and m_req_ready=1
  - cycle 2: m_rsp_valid and rsp_valid
  - cycle 3: IDLE, next grant
- Peak throughput: one transaction per 3 cycles.
- m_req_ready low stretches REQ; m_rsp_valid low stretches RSP. Both are unbounded with no timeout.
- No combinational path from m_req_ready to the requester ready outputs. The only combinational path from a memory input to a requester output is m_rsp_* to *_rsp_*.

## Test plan
- Lone fetch, addr 0x100, m_rsp_data 0xDEADBEEF at cycle 2 -> i_req_ready at cycle 0, m_req_addr=0x100 and we=0 at cycle 1, i_rsp_valid=1 with data 0xDEADBEEF at cycle 2, d_rsp_valid never 1.
- Both valid continuously, STARVE_LIMIT=4, memory always ready -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt reads 4 immediately before each fetch grant.
- Data write addr 0x40, wdata 0x12345678, wstrb 4'b0011, m_req_ready held low 5 cycles -> m_req_* stable for all 6 cycles of m_req_valid; the ack yields d_rsp_valid=1 for one cycle.
- Fetch granted, response delayed 10 cycles while d_req_valid=1 -> d_req_ready=0 throughout; the data grant comes in the cycle after i_rsp_valid.
- m_rsp_valid pulsed in IDLE -> no rsp_valid on either requester, err_unexp_rsp=1 and held until reset.
- areset_n asserted in RSP state, then m_rsp_valid arrives after release -> no rsp_valid, state IDLE, err_unexp_rsp=1; all outputs 0 during reset.
